// File: rtl/led_uart_reporter.sv
// -----------------------------------------------------------------------------
// led_uart_reporter
//
// Watches the ALU's 8-bit LED register and sends every new value out as a
// UART frame. The frame is 8N1 by default: one start bit, 8 data bits LSB
// first, and one stop bit. If a value changes while a frame is still being
// sent, the pending value is replaced by the newest one, and the number of
// pending values that were overwritten is counted. That count saturates at
// 8'hFF.
//
// Optional feature macro: LED_UART_PARITY_EN
//   When defined, an even-parity bit is inserted after the data bits, giving
//   an 11-bit frame.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit, legal range 2..65535
//
// Ports
//   Clock      in   rising-edge system clock
//   Reset      in   asynchronous reset, active low
//   iLed       in   [7:0] LED register value, synchronous to Clock
//   oTx        out  UART serial line, idles high (registered)
//   oBusy      out  high from the start bit through the stop bit (registered)
//   oCoalesced out  [7:0] saturating count of overwritten pending values
// -----------------------------------------------------------------------------
module led_uart_reporter #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iLed,
  output logic       oTx,
  output logic       oBusy,
  output logic [7:0] oCoalesced
);

  localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef LED_UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t      state_q,     state_d;
  logic [15:0] bit_cnt_q,   bit_cnt_d;
  logic [2:0]  bit_idx_q,   bit_idx_d;
  logic [7:0]  shift_q,     shift_d;
  logic [7:0]  last_seen_q, last_seen_d;
  logic [7:0]  pend_data_q, pend_data_d;
  logic        pending_q,   pending_d;
  logic [7:0]  coalesced_q, coalesced_d;
  logic        tx_q,        tx_d;
  logic        busy_q,      busy_d;

  logic change;
  logic load;
  logic tick_end;

  always_comb begin
    last_seen_d = last_seen_q;
    pend_data_d = pend_data_q;
    pending_d   = pending_q;
    coalesced_d = coalesced_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q + 16'd1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    tx_d        = 1'b1;
    busy_d      = 1'b0;

    change   = (iLed != last_seen_q);
    load     = (state_q == S_IDLE) && pending_q;
    tick_end = (bit_cnt_q == LAST_TICK);

    // Change detector. When a load and a change happen on the same edge,
    // the load takes the old pending value and the new value re-arms
    // pending. This case is not counted as an overwrite.
    if (change) begin
      last_seen_d = iLed;
      pend_data_d = iLed;
      pending_d   = 1'b1;
      if (pending_q && !load && (coalesced_q != 8'hFF)) begin
        coalesced_d = coalesced_q + 8'd1;
      end
    end else if (load) begin
      pending_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (load) begin
          shift_d = pend_data_q;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (tick_end) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef LED_UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef LED_UART_PARITY_EN
      S_PARITY: begin
        if (tick_end) begin
          state_d   = S_STOP;
          bit_cnt_d = '0;
        end
      end
`endif
      S_STOP: begin
        if (tick_end) begin
          state_d   = S_IDLE;
          bit_cnt_d = '0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
      end
    endcase

    // The line outputs are decoded from the next state so that they can be
    // registered without adding a cycle of latency. As a result, oTx falls
    // on the same edge that loads the frame.
    case (state_d)
      S_START:    tx_d = 1'b0;
      S_DATA:     tx_d = shift_d[bit_idx_d];
`ifdef LED_UART_PARITY_EN
      S_PARITY:   tx_d = ^shift_d;
`endif
      default:    tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      last_seen_q <= '0;
      pend_data_q <= '0;
      pending_q   <= 1'b0;
      coalesced_q <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      last_seen_q <= last_seen_d;
      pend_data_q <= pend_data_d;
      pending_q   <= pending_d;
      coalesced_q <= coalesced_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

  assign oTx        = tx_q;
  assign oBusy      = busy_q;
  assign oCoalesced = coalesced_q;

endmodule
